// File: rtl/clock_bcd_pkg.sv
// Shared constants and types for the clock system's binary-to-BCD conversion path.
//   DIGIT_W       width of one BCD digit
//   MAX_BCD_VAL   largest value representable in four BCD digits; larger operands clamp here
//   BLANK_CODE    digit code the 7-segment decoder shows as a blank
//   DEFAULT_BIN_W default binary operand width (also the shift count per conversion)
//   state_t       conversion FSM states
package clock_bcd_pkg;

  localparam int unsigned DIGIT_W       = 4;
  localparam int unsigned MAX_BCD_VAL   = 9999;
  localparam logic [3:0]  BLANK_CODE    = 4'hF;
  localparam int unsigned DEFAULT_BIN_W = 14;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

endpackage

// File: rtl/bcd_dabble_step.sv
// One combinational shift-add-3 (double dabble) iteration.
// Ports:
//   tho_i/hun_i/ten_i/one_i  current BCD digits
//   bit_i                    next operand bit, shifted into the ones digit
//   tho_o/hun_o/ten_o/one_o  digits after adjust-and-shift
// The thousands digit never exceeds 9 for clamped operands, so its carry-out is dropped.
module bcd_dabble_step
  import clock_bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] tho_i,
  input  logic [DIGIT_W-1:0] hun_i,
  input  logic [DIGIT_W-1:0] ten_i,
  input  logic [DIGIT_W-1:0] one_i,
  input  logic               bit_i,
  output logic [DIGIT_W-1:0] tho_o,
  output logic [DIGIT_W-1:0] hun_o,
  output logic [DIGIT_W-1:0] ten_o,
  output logic [DIGIT_W-1:0] one_o
);

  logic [2:0]         tho_adj;
  logic [DIGIT_W-1:0] hun_adj;
  logic [DIGIT_W-1:0] ten_adj;
  logic [DIGIT_W-1:0] one_adj;

  // Only the low three bits of the adjusted thousands digit survive the shift.
  assign tho_adj = tho_i[2:0] + ((tho_i >= 4'd5) ? 3'd3 : 3'd0);
  assign hun_adj = (hun_i >= 4'd5) ? hun_i + 4'd3 : hun_i;
  assign ten_adj = (ten_i >= 4'd5) ? ten_i + 4'd3 : ten_i;
  assign one_adj = (one_i >= 4'd5) ? one_i + 4'd3 : one_i;

  assign tho_o = {tho_adj,      hun_adj[3]};
  assign hun_o = {hun_adj[2:0], ten_adj[3]};
  assign ten_o = {ten_adj[2:0], one_adj[3]};
  assign one_o = {one_adj[2:0], bit_i};

endmodule

// File: rtl/bcd_conv_arbiter.sv
// Round-robin arbiter sharing one serial binary-to-BCD converter among N_REQ requesters.
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   req_valid/req_ready      per-requester handshake; req_ready is a one-hot grant in IDLE
//   req_bin                  packed operands, requester i at [i*BIN_W +: BIN_W]
//   rsp_valid/rsp_ready      result handshake
//   rsp_id                   requester index of the result
//   rsp_tho..rsp_one         BCD digits of the result
//   rsp_ovf                  operand exceeded 9999 and was clamped
//   busy                     converter is not idle
// Build option: define BCD_BLANK_LEADING_ZERO_EN to replace leading zero digits with BLANK_CODE.
module bcd_conv_arbiter
  import clock_bcd_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned BIN_W = DEFAULT_BIN_W,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*BIN_W-1:0] req_bin,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [DIGIT_W-1:0]     rsp_tho,
  output logic [DIGIT_W-1:0]     rsp_hun,
  output logic [DIGIT_W-1:0]     rsp_ten,
  output logic [DIGIT_W-1:0]     rsp_one,
  output logic                   rsp_ovf,
  output logic                   busy
);

  localparam int unsigned CNT_W = $clog2(BIN_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

  state_t state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               ovf_q, ovf_d;
  logic [BIN_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DIGIT_W-1:0] acc_tho_q, acc_hun_q, acc_ten_q, acc_one_q;
  logic [DIGIT_W-1:0] acc_tho_d, acc_hun_d, acc_ten_d, acc_one_d;
  logic [DIGIT_W-1:0] rsp_tho_q, rsp_hun_q, rsp_ten_q, rsp_one_q;
  logic [DIGIT_W-1:0] rsp_tho_d, rsp_hun_d, rsp_ten_d, rsp_one_d;
  logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
  logic               rsp_ovf_q, rsp_ovf_d;

  logic [DIGIT_W-1:0] step_tho, step_hun, step_ten, step_one;
  logic [DIGIT_W-1:0] fin_tho, fin_hun, fin_ten, fin_one;
  logic [N_REQ-1:0]   grant;
  logic [ID_W-1:0]    grant_id;
  logic               found;
  logic [BIN_W-1:0]   sel_bin;

  // Round-robin search starting just above the last granted requester.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      if (!found && req_valid[(int'(ptr_q) + k) % int'(N_REQ)]) begin
        found = 1'b1;
        grant[(int'(ptr_q) + k) % int'(N_REQ)] = 1'b1;
        grant_id = ID_W'((int'(ptr_q) + k) % int'(N_REQ));
      end
    end
  end

  assign sel_bin = req_bin[int'(grant_id)*BIN_W +: BIN_W];

  bcd_dabble_step u_step (
    .tho_i (acc_tho_q),
    .hun_i (acc_hun_q),
    .ten_i (acc_ten_q),
    .one_i (acc_one_q),
    .bit_i (op_q[BIN_W-1]),
    .tho_o (step_tho),
    .hun_o (step_hun),
    .ten_o (step_ten),
    .one_o (step_one)
  );

`ifdef BCD_BLANK_LEADING_ZERO_EN
  logic blank_tho, blank_hun, blank_ten;

  // A digit blanks only when it and every digit above it are zero; ones stays numeric.
  always_comb begin
    blank_tho = (step_tho == '0);
    blank_hun = blank_tho && (step_hun == '0);
    blank_ten = blank_hun && (step_ten == '0);
    fin_tho   = blank_tho ? BLANK_CODE : step_tho;
    fin_hun   = blank_hun ? BLANK_CODE : step_hun;
    fin_ten   = blank_ten ? BLANK_CODE : step_ten;
    fin_one   = step_one;
  end
`else
  always_comb begin
    fin_tho = step_tho;
    fin_hun = step_hun;
    fin_ten = step_ten;
    fin_one = step_one;
  end
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    id_d      = id_q;
    ovf_d     = ovf_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_tho_d = acc_tho_q;
    acc_hun_d = acc_hun_q;
    acc_ten_d = acc_ten_q;
    acc_one_d = acc_one_q;
    rsp_tho_d = rsp_tho_q;
    rsp_hun_d = rsp_hun_q;
    rsp_ten_d = rsp_ten_q;
    rsp_one_d = rsp_one_q;
    rsp_id_d  = rsp_id_q;
    rsp_ovf_d = rsp_ovf_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          ptr_d = grant_id;
          id_d  = grant_id;
          if (32'(sel_bin) > MAX_BCD_VAL) begin
            op_d  = BIN_W'(MAX_BCD_VAL);
            ovf_d = 1'b1;
          end else begin
            op_d  = sel_bin;
            ovf_d = 1'b0;
          end
          acc_tho_d = '0;
          acc_hun_d = '0;
          acc_ten_d = '0;
          acc_one_d = '0;
          cnt_d     = '0;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        acc_tho_d = step_tho;
        acc_hun_d = step_hun;
        acc_ten_d = step_ten;
        acc_one_d = step_one;
        op_d      = op_q << 1;
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          // Result registers load with the final iteration so DONE adds no latency.
          rsp_tho_d = fin_tho;
          rsp_hun_d = fin_hun;
          rsp_ten_d = fin_ten;
          rsp_one_d = fin_one;
          rsp_id_d  = id_q;
          rsp_ovf_d = ovf_q;
          state_d   = DONE;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      ptr_q     <= ID_W'(N_REQ - 1);
      id_q      <= '0;
      ovf_q     <= 1'b0;
      op_q      <= '0;
      cnt_q     <= '0;
      acc_tho_q <= '0;
      acc_hun_q <= '0;
      acc_ten_q <= '0;
      acc_one_q <= '0;
      rsp_tho_q <= '0;
      rsp_hun_q <= '0;
      rsp_ten_q <= '0;
      rsp_one_q <= '0;
      rsp_id_q  <= '0;
      rsp_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      id_q      <= id_d;
      ovf_q     <= ovf_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_tho_q <= acc_tho_d;
      acc_hun_q <= acc_hun_d;
      acc_ten_q <= acc_ten_d;
      acc_one_q <= acc_one_d;
      rsp_tho_q <= rsp_tho_d;
      rsp_hun_q <= rsp_hun_d;
      rsp_ten_q <= rsp_ten_d;
      rsp_one_q <= rsp_one_d;
      rsp_id_q  <= rsp_id_d;
      rsp_ovf_q <= rsp_ovf_d;
    end
  end

  // Grants are suppressed while reset is held so nothing appears captured.
  assign req_ready = (state_q == IDLE && rst) ? grant : '0;
  assign rsp_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign rsp_id    = rsp_id_q;
  assign rsp_tho   = rsp_tho_q;
  assign rsp_hun   = rsp_hun_q;
  assign rsp_ten   = rsp_ten_q;
  assign rsp_one   = rsp_one_q;
  assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
// Self-checking bench for bcd_conv_arbiter: directed scenarios with random operands,
// compared against an arithmetic model of the expected digits and round-robin order.
module tb_bcd_conv_arbiter;

  localparam int N = 4;
  localparam int W = 14;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_bin;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [3:0]     rsp_tho, rsp_hun, rsp_ten, rsp_one;
  logic           rsp_ovf;
  logic           busy;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int exp_ptr;

  bcd_conv_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_bin   (req_bin),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_tho   (rsp_tho),
    .rsp_hun   (rsp_hun),
    .rsp_ten   (rsp_ten),
    .rsp_one   (rsp_one),
    .rsp_ovf   (rsp_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal digits of the clamped value, optionally with leading zeros blanked.
  function automatic logic [15:0] exp_digits(input int v);
    int c;
    logic [3:0] t, h, te, o;
    c  = (v > 9999) ? 9999 : v;
    t  = 4'(c / 1000);
    h  = 4'((c / 100) % 10);
    te = 4'((c / 10) % 10);
    o  = 4'(c % 10);
`ifdef BCD_BLANK_LEADING_ZERO_EN
    if (c < 1000) t = 4'hF;
    if (c < 100)  h = 4'hF;
    if (c < 10)   te = 4'hF;
`endif
    return {t, h, te, o};
  endfunction

  function automatic logic [3:0] exp_grant(input logic [3:0] v, input int p);
    logic [3:0] g;
    g = '0;
    for (int k = 1; k <= N; k++) begin
      if (g == '0 && v[(p + k) % N]) g[(p + k) % N] = 1'b1;
    end
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
  endtask

  task automatic set_bin(input int id, input logic [13:0] v);
    req_bin[id*W +: W] = v;
  endtask

  task automatic run_one(input int id, input logic [13:0] v, input string tag);
    int lat;
    set_bin(id, v);
    req_valid = 4'(1 << id);
    rsp_ready = 1'b1;
    #1;
    check({tag, " grant"}, 32'(req_ready), 32'(exp_grant(req_valid, exp_ptr)));
    tick();
    exp_ptr   = id;
    req_valid = '0;
    check({tag, " busy"}, 32'(busy), 32'd1);
    wait_rsp(lat);
    check({tag, " latency"}, 32'(lat), 32'd14);
    check({tag, " digits"}, {16'd0, rsp_tho, rsp_hun, rsp_ten, rsp_one}, 32'(exp_digits(int'(v))));
    check({tag, " id"}, 32'(rsp_id), 32'(id));
    check({tag, " ovf"}, 32'(rsp_ovf), 32'(int'(v) > 9999));
    tick();
    check({tag, " valid drop"}, 32'(rsp_valid), 32'd0);
    check({tag, " hold"}, {16'd0, rsp_tho, rsp_hun, rsp_ten, rsp_one}, 32'(exp_digits(int'(v))));
  endtask

  initial begin
    int lat, prev_cap, eid, hits, spin;
    logic [13:0] vals [N];

    rst       = 1'b0;
    req_valid = '0;
    req_bin   = '0;
    rsp_ready = 1'b0;
    exp_ptr   = N - 1;

    // Reset state, with requests pending to confirm no grant under reset.
    repeat (3) tick();
    req_valid = 4'hF;
    #1;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_id", 32'(rsp_id), 32'd0);
    check("reset digits", {16'd0, rsp_tho, rsp_hun, rsp_ten, rsp_one}, 32'd0);
    check("reset ovf", 32'(rsp_ovf), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset req_ready", 32'(req_ready), 32'd0);
    req_valid = '0;
    rst = 1'b1;
    tick();

    run_one(1, 14'd1234, "t1234");
    run_one(1, 14'd16383, "t16383");
    run_one(2, 14'd0, "tzero");
    run_one(0, 14'd9999, "t9999");
    run_one(3, 14'd10000, "t10000");
    for (int i = 0; i < 8; i++) begin
      run_one(int'($urandom_range(0, 3)), 14'($urandom_range(0, 16383)), "rand");
    end

    // Backpressure in DONE with a competing request pending.
    set_bin(3, 14'd4321);
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    #1;
    check("bp grant", 32'(req_ready), 32'(exp_grant(req_valid, exp_ptr)));
    tick();
    exp_ptr = 3;
    set_bin(0, 14'd777);
    req_valid = 4'b0001;
    wait_rsp(lat);
    check("bp latency", 32'(lat), 32'd14);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp valid", 32'(rsp_valid), 32'd1);
      check("bp digits", {16'd0, rsp_tho, rsp_hun, rsp_ten, rsp_one}, 32'(exp_digits(4321)));
      check("bp req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    tick();
    check("bp idle valid", 32'(rsp_valid), 32'd0);
    check("bp idle busy", 32'(busy), 32'd0);
    check("bp next grant", 32'(req_ready), 32'(exp_grant(4'b0001, exp_ptr)));
    tick();
    exp_ptr = 0;
    req_valid = '0;
    wait_rsp(lat);
    check("bp2 digits", {16'd0, rsp_tho, rsp_hun, rsp_ten, rsp_one}, 32'(exp_digits(777)));
    check("bp2 id", 32'(rsp_id), 32'd0);
    tick();

    // Requester 2 pulses valid while the converter is busy and must never be served.
    set_bin(1, 14'd3050);
    set_bin(2, 14'd2222);
    req_valid = 4'b0010;
    #1;
    check("drop grant", 32'(req_ready), 32'(exp_grant(req_valid, exp_ptr)));
    tick();
    exp_ptr = 1;
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    wait_rsp(lat);
    check("drop latency", 32'(lat + 1), 32'd14);
    check("drop id", 32'(rsp_id), 32'd1);
    check("drop digits", {16'd0, rsp_tho, rsp_hun, rsp_ten, rsp_one}, 32'(exp_digits(3050)));
    tick();
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid !== 1'b0 || busy !== 1'b0) hits++;
    end
    check("drop no service", 32'(hits), 32'd0);

    // Reset during the seventh shift iteration aborts the conversion.
    set_bin(1, 14'd5678);
    req_valid = 4'b0010;
    #1;
    check("abort grant", 32'(req_ready), 32'(exp_grant(req_valid, exp_ptr)));
    tick();
    req_valid = '0;
    repeat (7) tick();
    check("abort busy", 32'(busy), 32'd1);
    rst = 1'b0;
    #1;
    exp_ptr = N - 1;
    check("abort rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort digits", {16'd0, rsp_tho, rsp_hun, rsp_ten, rsp_one}, 32'd0);
    check("abort id", 32'(rsp_id), 32'd0);
    check("abort ovf", 32'(rsp_ovf), 32'd0);
    check("abort busy low", 32'(busy), 32'd0);
    tick();
    rst = 1'b1;
    hits = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid !== 1'b0) hits++;
    end
    check("abort no rsp", 32'(hits), 32'd0);
    set_bin(0, 14'd5678);
    set_bin(3, 14'd1111);
    req_valid = 4'b1001;
    #1;
    check("post-reset grant", 32'(req_ready), 32'(exp_grant(req_valid, exp_ptr)));
    tick();
    exp_ptr = 0;
    req_valid = '0;
    wait_rsp(lat);
    check("post-reset latency", 32'(lat), 32'd14);
    check("post-reset digits", {16'd0, rsp_tho, rsp_hun, rsp_ten, rsp_one}, 32'(exp_digits(5678)));
    check("post-reset id", 32'(rsp_id), 32'd0);
    tick();

    // All requesters valid continuously after a fresh reset.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp_ptr = N - 1;
    for (int i = 0; i < N; i++) begin
      vals[i] = 14'(i * 2000 + int'($urandom_range(0, 1999)));
      set_bin(i, vals[i]);
    end
    req_valid = 4'hF;
    rsp_ready = 1'b1;
    #1;
    prev_cap = 0;
    for (int g = 0; g < 5; g++) begin
      spin = 0;
      while (req_ready == '0 && spin < 40) begin
        tick();
        spin++;
      end
      check("rr wait", 32'(spin < 40), 32'd1);
      eid = (exp_ptr + 1) % N;
      check("rr grant", 32'(req_ready), 32'(exp_grant(req_valid, exp_ptr)));
      if (g > 0) check("rr period", 32'(cyc - prev_cap), 32'd16);
      prev_cap = cyc;
      tick();
      exp_ptr = eid;
      wait_rsp(lat);
      check("rr latency", 32'(lat), 32'd14);
      check("rr id", 32'(rsp_id), 32'(eid));
      check("rr digits", {16'd0, rsp_tho, rsp_hun, rsp_ten, rsp_one}, 32'(exp_digits(int'(vals[eid]))));
      tick();
    end
    req_valid = '0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_conv_arbiter.md
Name: bcd_conv_arbiter

Overview:
- Shares one multi-cycle binary-to-BCD conversion engine among N_REQ requesters in the clock system (time, stopwatch, alarm, set-mode display paths).
- Round-robin arbitration with valid/ready handshakes.
- Serial shift-add-3 conversion, one input bit per cycle.
- Result is a 4-digit BCD response tagged with the requester id, feeding the 7-segment display mux.

Parameters:
- N_REQ, 4, number of requesters (2..8)
- BIN_W, 14, binary operand width; also the number of shift cycles per conversion
- ID_W, $clog2(N_REQ), width of the response id

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-low
- req_valid  input  N_REQ  per-requester conversion request
- req_bin  input  N_REQ*BIN_W  packed operands; requester i occupies bits [i*BIN_W +: BIN_W]
- req_ready  output  N_REQ  one-hot grant; request i is captured on the edge where req_valid[i] and req_ready[i] are both high
- rsp_valid  output  1  result available
- rsp_ready  input  1  consumer accepts the result
- rsp_id  output  ID_W  requester index of the current result
- rsp_tho, rsp_hun, rsp_ten, rsp_one  output  4 each  BCD digits
- rsp_ovf  output  1  operand exceeded 9999 and was clamped
- busy  output  1  high in every state except IDLE

Behaviour:
- Reset (async, rst low): state IDLE, all digits 0, rsp_valid 0, rsp_id 0, rsp_ovf 0, req_ready 0, last-grant pointer N_REQ-1 (requester 0 wins first). Reset mid-conversion aborts the conversion; no response is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - req_ready is combinational: one-hot to the first valid requester searching upward from pointer+1 with wrap-around; all zero if no request.
  - On capture: latch operand and id, update pointer, clear digit accumulators and counter, go to SHIFT.
- Clamp: operand > 9999 is replaced by 9999 at capture and the overflow flag is set. 14-bit inputs up to 16383 therefore never overflow the thousands digit.
- SHIFT: each cycle performs one iteration, MSB first:
  - add 3 to every digit >= 5;
  - shift {tho,hun,ten,one,operand} left by 1.
  - After BIN_W iterations (counter BIN_W-1 reached), go to DONE.
- DONE:
  - rsp_valid high; digits, id and ovf registered and stable.
  - Hold until rsp_valid && rsp_ready, then return to IDLE.
  - Backpressure is unbounded; no new request is accepted while in DONE.
- Timing: rsp_valid first high BIN_W cycles after the capture edge. Minimum request-to-request period is BIN_W+2 cycles.
- Outputs hold the last result after the handshake; rsp_valid is 0.
- A requester may drop req_valid at any time before capture. It is then ignored with no side effects.
- Simultaneous requests are resolved only by the round-robin pointer. No requester waits more than N_REQ-1 other conversions.
- The pointer updates only on capture.

Optional Feature:
- Macro: BCD_BLANK_LEADING_ZERO_EN
- Defined:
  - leading zero digits of the response are replaced with 4'hF (display blank code);
  - rsp_one is always numeric;
  - e.g. 42 gives F,F,4,2.
- Undefined: digits are always 0..9 (e.g. 0,0,4,2).
- Blanking is applied when loading the DONE registers, so latency is unchanged.

Decomposition:
- Package clock_bcd_pkg holds:
  - DIGIT_W=4, MAX_BCD_VAL=9999, BLANK_CODE=4'hF;
  - state enum {IDLE,SHIFT,DONE};
  - the default BIN_W.
- One natural sub-module: bcd_dabble_step, a combinational single iteration. Inputs are four digits and an incoming bit; outputs are four digits. It is instantiated once in SHIFT.

Test Plan:
- Single requester 1, req_bin=1234, rsp_ready=1:
  - req_ready[1] pulses; rsp_valid rises 14 cycles after capture;
  - digits 1,2,3,4; rsp_id=1; rsp_ovf=0.
- Operand 16383 → digits 9,9,9,9 and rsp_ovf=1. Operand 0 → 0,0,0,0, or F,F,F,0 with BCD_BLANK_LEADING_ZERO_EN.
- All four requesters valid continuously with distinct values:
  - grants in order 0,1,2,3,0;
  - each response carries the matching id and value;
  - period 16 cycles.
- rsp_ready held low for 20 cycles in DONE:
  - rsp_valid and digits stable;
  - req_ready stays 0;
  - on rsp_ready=1, IDLE for one cycle and the next grant issues.
- rst asserted at SHIFT iteration 7 while converting 5678:
  - all outputs immediately 0;
  - after release, a new 5678 request converts correctly;
  - requester 0 has priority.
- Requester 2 raises req_valid for one cycle while the block is busy, then drops it → never granted; no response with rsp_id=2.
